// File: rtl/vga_pkg.sv
// Shared defaults for the display blocks: geometry, colour width and transparency key.
package vga_pkg;

    localparam int         PIX_W_DEF     = 12;
    localparam int         LOGO_W_DEF    = 128;
    localparam int         LOGO_H_DEF    = 128;
    localparam int         H_BITS_DEF    = 10;
    localparam int         V_BITS_DEF    = 10;
    localparam int         ADDR_W_DEF    = 14;
    localparam bit         TRANSP_EN_DEF = 1'b1;
    localparam logic [11:0] TRANSP_KEY_DEF = 12'hF0F;

    typedef enum logic [1:0] {
        SRC_BLANK = 2'd0,
        SRC_BG    = 2'd1,
        SRC_LOGO  = 2'd2
    } pix_src_e;

endpackage

// File: rtl/sprite_addr_gen.sv
// Stage 0 of the sprite pipeline: per-frame position/scale latch, logo area test
// and ROM address generation.
module sprite_addr_gen
    import vga_pkg::*;
#(
    parameter int LOGO_W = LOGO_W_DEF,
    parameter int LOGO_H = LOGO_H_DEF,
    parameter int H_BITS = H_BITS_DEF,
    parameter int V_BITS = V_BITS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [H_BITS-1:0] h_cnt,
    input  logic [V_BITS-1:0] v_cnt,
    input  logic              valid,
    input  logic [H_BITS-1:0] pos_x,
    input  logic [V_BITS-1:0] pos_y,
    input  logic              scale2,
    output logic              in_area,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en
);

    localparam int HX = H_BITS + 2;
    localparam int VX = V_BITS + 2;

    logic [H_BITS-1:0] lat_x, cur_x;
    logic [V_BITS-1:0] lat_y, cur_y;
    logic              lat_s2, cur_s2, frame_start;
    logic [HX-1:0]     h_ext, x_ext, x_end, dh, col;
    logic [VX-1:0]     v_ext, y_ext, y_end, dv, row;
    logic [ADDR_W-1:0] addr_next;

    // On the frame-start pixel itself the fresh request is used, so the whole
    // frame is drawn with one consistent position and scale.
    always_comb begin
        frame_start = (h_cnt == '0) && (v_cnt == '0);
        cur_x  = frame_start ? pos_x  : lat_x;
        cur_y  = frame_start ? pos_y  : lat_y;
        cur_s2 = frame_start ? scale2 : lat_s2;

        h_ext = HX'(h_cnt);
        x_ext = HX'(cur_x);
        x_end = x_ext + (cur_s2 ? HX'(2 * LOGO_W) : HX'(LOGO_W));
        v_ext = VX'(v_cnt);
        y_ext = VX'(cur_y);
        y_end = y_ext + (cur_s2 ? VX'(2 * LOGO_H) : VX'(LOGO_H));

        in_area = valid && (h_ext >= x_ext) && (h_ext < x_end)
                        && (v_ext >= y_ext) && (v_ext < y_end);

        dh  = h_ext - x_ext;
        dv  = v_ext - y_ext;
        col = cur_s2 ? (dh >> 1) : dh;
        row = cur_s2 ? (dv >> 1) : dv;
        addr_next = ADDR_W'(32'(row) * 32'(LOGO_W) + 32'(col));
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            lat_x    <= '0;
            lat_y    <= '0;
            lat_s2   <= 1'b0;
            rom_addr <= '0;
            rom_en   <= 1'b0;
        end else begin
            if (frame_start) begin
                lat_x  <= pos_x;
                lat_y  <= pos_y;
                lat_s2 <= scale2;
            end
            rom_en <= in_area;
            if (in_area) begin
                rom_addr <= addr_next;
            end
        end
    end

endmodule

// File: rtl/sprite_display.sv
// Logo overlay: address generation, alignment of video/area flags with ROM data,
// and the registered output colour mux with colour-key transparency.
module sprite_display
    import vga_pkg::*;
#(
    parameter int               PIX_W      = PIX_W_DEF,
    parameter int               LOGO_W     = LOGO_W_DEF,
    parameter int               LOGO_H     = LOGO_H_DEF,
    parameter int               H_BITS     = H_BITS_DEF,
    parameter int               V_BITS     = V_BITS_DEF,
    parameter int               ADDR_W     = ADDR_W_DEF,
    parameter bit               TRANSP_EN  = TRANSP_EN_DEF,
    parameter logic [PIX_W-1:0] TRANSP_KEY = PIX_W'(TRANSP_KEY_DEF)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [H_BITS-1:0] h_cnt,
    input  logic [V_BITS-1:0] v_cnt,
    input  logic              valid,
    input  logic [H_BITS-1:0] pos_x,
    input  logic [V_BITS-1:0] pos_y,
    input  logic              scale2,
    input  logic [PIX_W-1:0]  bg_color,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [PIX_W-1:0]  rom_douta,
    output logic [PIX_W-1:0]  vga_data,
    output logic              logo_hit
);

    logic     in_area, valid_d, area_d;
    pix_src_e src;

    sprite_addr_gen #(
        .LOGO_W (LOGO_W),
        .LOGO_H (LOGO_H),
        .H_BITS (H_BITS),
        .V_BITS (V_BITS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .pclk     (pclk),
        .rst      (rst),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .valid    (valid),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .scale2   (scale2),
        .in_area  (in_area),
        .rom_addr (rom_addr),
        .rom_en   (rom_en)
    );

    always_comb begin
        src = SRC_LOGO;
        if (!valid_d) begin
            src = SRC_BLANK;
        end else if (!area_d) begin
            src = SRC_BG;
        end else if (TRANSP_EN && (rom_douta == TRANSP_KEY)) begin
            src = SRC_BG;
        end
    end

    // valid_d/area_d line up with rom_douta, which answers the registered rom_addr.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            valid_d  <= 1'b0;
            area_d   <= 1'b0;
            vga_data <= '0;
            logo_hit <= 1'b0;
        end else begin
            valid_d <= valid;
            area_d  <= in_area;
            case (src)
                SRC_BLANK: begin
                    vga_data <= '0;
                    logo_hit <= 1'b0;
                end
                SRC_BG: begin
                    vga_data <= bg_color;
                    logo_hit <= 1'b0;
                end
                default: begin
                    vga_data <= rom_douta;
                    logo_hit <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_display.sv
// Bench for sprite_display: directed raster scenarios plus randomized pixels, all
// checked every cycle against a frame-level reference model of the overlay.
module tb_sprite_display;

    localparam int LW  = 128;
    localparam int LH  = 128;
    localparam int KEY = 12'hF0F;

    logic        pclk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt, pos_x, pos_y;
    logic        valid, scale2;
    logic [11:0] bg_color;
    logic [13:0] rom_addr;
    logic        rom_en;
    logic [11:0] rom_douta, vga_data;
    logic        logo_hit;

    always #5 pclk = ~pclk;

    // Logo image content; every seventh word from 3 is the transparency key.
    function automatic logic [11:0] rom_fn(int a);
        if (a % 7 == 3) return 12'hF0F;
        return 12'((a * 29 + 7) % 4096);
    endfunction

    assign rom_douta = rom_fn(int'(rom_addr));

    sprite_display dut (
        .pclk      (pclk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .valid     (valid),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .scale2    (scale2),
        .bg_color  (bg_color),
        .rom_addr  (rom_addr),
        .rom_en    (rom_en),
        .rom_douta (rom_douta),
        .vga_data  (vga_data),
        .logo_hit  (logo_hit)
    );

    int checks = 0;
    int errors = 0;

    // Driven request values
    int d_px = 0, d_py = 0, d_bg = 0;
    bit d_s2 = 1'b0, d_rst = 1'b0;

    // Reference model state: frame settings and expected visible outputs
    int m_x = 0, m_y = 0, m_s = 1;
    int e_addr = 0, e_en = 0, e_v1 = 0, e_a1 = 0, e_vga = 0, e_hit = 0;

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(int h, int v, bit val);
        int nv, nh, d, area;
        if (!d_rst) begin
            m_x = 0; m_y = 0; m_s = 1;
            e_addr = 0; e_en = 0; e_v1 = 0; e_a1 = 0; e_vga = 0; e_hit = 0;
            return;
        end
        nh = 0;
        if (e_v1 == 0) nv = 0;
        else if (e_a1 == 0) nv = d_bg;
        else begin
            d = int'(rom_fn(e_addr));
            if (d == KEY) nv = d_bg;
            else begin
                nv = d;
                nh = 1;
            end
        end
        if (h == 0 && v == 0) begin
            m_x = d_px; m_y = d_py; m_s = d_s2 ? 2 : 1;
        end
        area = (val && h >= m_x && h < m_x + LW * m_s && v >= m_y && v < m_y + LH * m_s) ? 1 : 0;
        if (area != 0) e_addr = ((v - m_y) / m_s) * LW + (h - m_x) / m_s;
        e_en  = area;
        e_v1  = val ? 1 : 0;
        e_a1  = area;
        e_vga = nv;
        e_hit = nh;
    endfunction

    task automatic step(int h, int v, bit val);
        @(negedge pclk);
        rst      = d_rst;
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        valid    = val;
        pos_x    = 10'(d_px);
        pos_y    = 10'(d_py);
        scale2   = d_s2;
        bg_color = 12'(d_bg);
        @(posedge pclk);
        model_edge(h, v, val);
        #1;
        check("rom_addr", int'(rom_addr), e_addr);
        check("rom_en", int'(rom_en), e_en);
        check("vga_data", int'(vga_data), e_vga);
        check("logo_hit", int'(logo_hit), e_hit);
    endtask

    initial begin
        int h, v, fx, fy;
        // Reset with arbitrary raster activity
        d_rst = 1'b0;
        d_bg  = 12'hABC;
        for (int i = 0; i < 3; i++) step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
        check("rst_vga", int'(vga_data), 0);
        check("rst_addr", int'(rom_addr), 0);
        d_rst = 1'b1;

        // 1x logo at (100,50)
        d_px = 100; d_py = 50; d_s2 = 1'b0; d_bg = 12'h123;
        step(0, 0, 1'b1);
        step(99, 50, 1'b1);
        step(100, 50, 1'b1);
        check("first_addr", int'(rom_addr), 0);
        check("first_en", int'(rom_en), 1);
        step(101, 50, 1'b1);
        check("first_pix", int'(vga_data), int'(rom_fn(0)));
        check("first_hit", int'(logo_hit), 1);
        step(102, 50, 1'b1);
        step(103, 50, 1'b1);
        step(104, 50, 1'b1);
        check("transp_vga", int'(vga_data), 12'h123);
        check("transp_hit", int'(logo_hit), 0);

        step(226, 177, 1'b1);
        step(227, 177, 1'b1);
        check("last_addr", int'(rom_addr), 16383);
        step(228, 177, 1'b1);
        check("past_en", int'(rom_en), 0);
        check("past_addr_hold", int'(rom_addr), 16383);
        step(229, 177, 1'b1);
        check("past_vga_bg", int'(vga_data), 12'h123);

        step(150, 100, 1'b0);
        step(151, 100, 1'b1);
        check("blank_vga", int'(vga_data), 0);

        // Mid-frame position change is ignored until the next frame start
        d_px = 300;
        step(100, 60, 1'b1);
        check("mid_en", int'(rom_en), 1);
        check("mid_addr", int'(rom_addr), 1280);
        d_px = 100;

        // 2x replication
        d_s2 = 1'b1;
        step(0, 0, 1'b1);
        d_s2 = 1'b0;
        step(102, 53, 1'b1);
        check("s2_addr", int'(rom_addr), 129);
        step(355, 305, 1'b1);
        check("s2_last_en", int'(rom_en), 1);
        check("s2_last_addr", int'(rom_addr), 16383);
        step(356, 305, 1'b1);
        check("s2_past_en", int'(rom_en), 0);

        // Logo clipped by the right/bottom edge of a 640x480 raster
        d_px = 600; d_py = 400;
        step(0, 0, 1'b1);
        for (int x = 595; x < 640; x++) step(x, 400, 1'b1);
        check("clip_addr_639", int'(rom_addr), 39);
        for (int x = 0; x < 4; x++) step(x, 401, 1'b1);
        check("nowrap_en", int'(rom_en), 0);
        step(639, 479, 1'b1);
        check("clip_corner", int'(rom_addr), 79 * 128 + 39);

        // Reset in the middle of a line
        d_px = 100; d_py = 50;
        step(0, 0, 1'b1);
        step(120, 60, 1'b1);
        step(121, 60, 1'b1);
        d_rst = 1'b0;
        step(122, 60, 1'b1);
        check("midrst_vga", int'(vga_data), 0);
        check("midrst_en", int'(rom_en), 0);
        check("midrst_addr", int'(rom_addr), 0);
        d_rst = 1'b1;
        step(5, 5, 1'b1);
        check("postrst_addr", int'(rom_addr), 645);

        // Randomized frames around the logo, with stray requests and resets
        for (int f = 0; f < 6; f++) begin
            d_px  = int'($urandom_range(0, 1000));
            d_py  = int'($urandom_range(0, 900));
            d_s2  = 1'($urandom_range(0, 1));
            d_bg  = int'($urandom_range(0, 4095));
            d_rst = 1'b1;
            fx = d_px;
            fy = d_py;
            step(0, 0, 1'b1);
            for (int i = 0; i < 250; i++) begin
                h = fx + int'($urandom_range(0, 280)) - 10;
                v = fy + int'($urandom_range(0, 280)) - 10;
                if (h < 0) h = 0;
                if (h > 1023) h = 1023;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                if ($urandom_range(0, 15) == 0) d_px = int'($urandom_range(0, 1023));
                d_rst = ($urandom_range(0, 149) != 0);
                step(h, v, ($urandom_range(0, 7) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_display.md
SPRITE_DISPLAY -- requirements
Module: sprite_display

Interface
REQ-001 Parameters SHALL be (name, default, meaning): PIX_W, 12, pixel bits per colour word.
REQ-002 LOGO_W, 128, image width in pixels; LOGO_H, 128, image height in pixels.
REQ-003 H_BITS, 10 and V_BITS, 10, counter widths; ADDR_W, 14, ROM address width, with LOGO_W*LOGO_H <= 2**ADDR_W.
REQ-004 TRANSP_EN, 1, colour-key enable; TRANSP_KEY, 12'hF0F, colour-key value.
REQ-005 Port pclk input 1: pixel clock; the block SHALL use one clock.
REQ-006 Port rst input 1: synchronous, active-low reset.
REQ-007 Ports h_cnt input H_BITS and v_cnt input V_BITS: current raster position.
REQ-008 Port valid input 1: active video region.
REQ-009 Ports pos_x input H_BITS and pos_y input V_BITS: requested logo top-left corner.
REQ-010 Port scale2 input 1: request 2x pixel replication.
REQ-011 Port bg_color input PIX_W: colour outside the logo and behind transparent pixels.
REQ-012 Ports rom_addr output ADDR_W and rom_en output 1: synchronous ROM read port; ROM read latency is 1 cycle.
REQ-013 Port rom_douta input PIX_W: ROM read data.
REQ-014 Ports vga_data output PIX_W and logo_hit output 1: pixel colour and opaque-logo-pixel flag.

Function
REQ-015 Frame start SHALL be h_cnt==0 && v_cnt==0; pos_x, pos_y and scale2 SHALL be latched only on the frame-start cycle, so mid-frame changes take effect at the next frame.
REQ-016 Span SHALL be s=1, or s=2 when latched scale2 is 1.
REQ-017 in_area SHALL be valid && h_cnt in [x, x+LOGO_W*s) && v_cnt in [y, y+LOGO_H*s).
REQ-018 The in_area comparisons SHALL use H_BITS+2 / V_BITS+2 bit arithmetic, so a logo partly beyond the right or bottom edge shows only its visible part and never wraps.
REQ-019 Stage 0 (cycle n): col=(h_cnt-x)>>(s-1) and row=(v_cnt-y)>>(s-1); rom_addr SHALL be registered as row*LOGO_W+col and rom_en as in_area.
REQ-020 Outside in_area, rom_addr SHALL hold its previous value and rom_en SHALL be 0.
REQ-021 Stage 1 (cycle n+1): valid and in_area SHALL be delayed to align with rom_douta.
REQ-022 Stage 2 (cycle n+2): vga_data SHALL be registered; total latency from h_cnt/v_cnt/valid to vga_data is exactly 2 cycles.
REQ-023 Output select, in priority order: delayed valid==0 -> 0; delayed in_area==0 -> bg_color; TRANSP_EN && rom_douta==TRANSP_KEY -> bg_color; otherwise rom_douta.
REQ-024 logo_hit SHALL be 1 only in the rom_douta case of REQ-023, aligned with vga_data.
REQ-025 Last pixel: col=LOGO_W-1 and row=LOGO_H-1 SHALL give address LOGO_W*LOGO_H-1; no address beyond it is issued.

Reset
REQ-026 While rst==0 at a pclk edge, all pipeline registers SHALL clear: vga_data=0, logo_hit=0, rom_en=0, rom_addr=0.
REQ-027 While rst==0, latched position SHALL clear to (0,0) and latched scale to 1x.
REQ-028 Reset mid-frame SHALL take effect at the next edge; after release, output SHALL resume with the latched values (0,0, 1x) until the next frame start.

Structure
REQ-029 The parameter defaults and TRANSP_KEY SHALL live in a shared package, vga_pkg, used by all display blocks.
REQ-030 Stage-0 area/address logic SHALL be sub-module sprite_addr_gen; the delay pipeline and output mux SHALL remain in sprite_display.

Verification
REQ-031 pos=(100,50), 1x, h=100,v=50,valid -> rom_addr=0 and rom_en=1 at n+1; vga_data=rom_douta at n+2.
REQ-032 pos=(100,50), 1x, h=227,v=177 -> rom_addr=16383; h=228 -> rom_en=0 and vga_data=bg_color at n+2.
REQ-033 Same pos, scale2=1 latched, h=102,v=53 -> rom_addr=1*128+1=129; h=355 -> still in area, addr=16383 at v=305.
REQ-034 pos=(600,400) on a 640x480 raster -> only cols 0-39 and rows 0-79 addressed; h=639 -> addr=row*128+39; no wrap at h=0.
REQ-035 rom_douta=12'hF0F inside area -> vga_data=bg_color, logo_hit=0; valid=0 anywhere -> vga_data=0.
REQ-036 pos_x changed mid-frame -> output unchanged until the next frame start; rst=0 mid-line -> all outputs 0 on the next edge.
